// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter for two requesters sharing a DATA_W-bit 2:1 mux.
// Limits consecutive grants with MAX_BURST, registers the selected data and counts transfers.
module mux_arbiter_rr #(
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 6
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              grant0,
  output logic              grant1,
  output logic              selector,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  contador
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

  localparam logic [5:0] BURST_LAST = 6'(MAX_BURST - 1);

  state_e              state_q, state_d;
  logic [5:0]          burst_q, burst_d;
  logic                last_q, last_d;
  logic                grant0_q, grant0_d;
  logic                grant1_q, grant1_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                xfer_s;
  logic [DATA_W-1:0]   xdata_s;

  // State register: arbitration state, burst length and last requester served
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      burst_q <= 6'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; a dropped request wins over the burst limit
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    xfer_s  = 1'b0;
    xdata_s = data_in0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? SERVE0 : SERVE1;
        end else if (req0) begin
          state_d = SERVE0;
        end else if (req1) begin
          state_d = SERVE1;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE0: begin
        if (!req0) begin
          burst_d = 6'd0;
          last_d  = 1'b0;
          state_d = req1 ? SERVE1 : IDLE;
        end else begin
          xfer_s  = 1'b1;
          xdata_s = data_in0;
          if (burst_q == BURST_LAST) begin
            burst_d = 6'd0;
            if (req1) begin
              state_d = SERVE1;
              last_d  = 1'b0;
            end else begin
              state_d = SERVE0;
            end
          end else begin
            burst_d = burst_q + 6'd1;
          end
        end
      end
      SERVE1: begin
        if (!req1) begin
          burst_d = 6'd0;
          last_d  = 1'b1;
          state_d = req0 ? SERVE0 : IDLE;
        end else begin
          xfer_s  = 1'b1;
          xdata_s = data_in1;
          if (burst_q == BURST_LAST) begin
            burst_d = 6'd0;
            if (req0) begin
              state_d = SERVE0;
              last_d  = 1'b1;
            end else begin
              state_d = SERVE1;
            end
          end else begin
            burst_d = burst_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = 6'd0;
      end
    endcase
  end

  // Output decode of the upcoming state; selector keeps its value through IDLE
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    sel_d    = sel_q;
    case (state_d)
      SERVE0: begin
        grant0_d = 1'b1;
        sel_d    = 1'b0;
      end
      SERVE1: begin
        grant1_d = 1'b1;
        sel_d    = 1'b1;
      end
      default: begin
        sel_d = sel_q;
      end
    endcase
    valid_d = xfer_s;
    if (xfer_s) begin
      data_d = xdata_s;
      cnt_d  = cnt_q + CNT_W'(1);
    end else begin
      data_d = data_q;
      cnt_d  = cnt_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      sel_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant0    = grant0_q;
  assign grant1    = grant1_q;
  assign selector  = sel_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign contador  = cnt_q;

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed and constrained-random checks for mux_arbiter_rr (MAX_BURST = 4).
module tb_mux_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       req0, req1;
  logic [1:0] data_in0, data_in1;
  logic       grant0, grant1, selector, valid_out;
  logic [1:0] data_out;
  logic [5:0] contador;

  int total;
  int bad;

  mux_arbiter_rr #(.DATA_W(2), .MAX_BURST(4), .CNT_W(6)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .req0     (req0),
    .req1     (req1),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .grant0   (grant0),
    .grant1   (grant1),
    .selector (selector),
    .data_out (data_out),
    .valid_out(valid_out),
    .contador (contador)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_g0"}, grant0, 0);
    chk({tag, "_g1"}, grant1, 0);
    chk({tag, "_sel"}, selector, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_cnt"}, contador, 0);
  endtask

  task automatic reset_pulse();
    reset_L = 1'b0;
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    int sb, w0, w1, max0, max1;
    logic xfer;
    logic [1:0] xd;
    total = 0; bad = 0;
    reset_L = 1'b0; req0 = 1'b0; req1 = 1'b0; data_in0 = 2'b00; data_in1 = 2'b00;
    #2;
    chk_reset("por");
    tick();
    reset_L = 1'b1;

    // both requesting: bursts of four, starting with requester 0
    req0 = 1'b1; req1 = 1'b1; data_in0 = 2'b01; data_in1 = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("alt_g0", grant0, (((k - 1) / 4) % 2) == 0);
      chk("alt_sel", selector, ((k - 1) / 4) % 2);
      if (k >= 2) begin
        chk("alt_data", data_out, ((((k - 2) / 4) % 2) != 0) ? 2'b10 : 2'b01);
        chk("alt_valid", valid_out, 1);
        chk("alt_cnt", contador, k - 1);
      end else begin
        chk("alt_valid0", valid_out, 0);
      end
    end

    // reset while requester 1 is mid-burst
    data_in0 = 2'b11;
    #2;
    reset_L = 1'b0;
    #1;
    chk_reset("mid");
    #2;
    reset_L = 1'b1;
    tick();
    chk("first_g0", grant0, 1);
    chk("first_g1", grant1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    reset_pulse();

    // single requester 1, no switch at the burst limit
    req1 = 1'b1; data_in1 = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("one_g1", grant1, 1);
      chk("one_g0", grant0, 0);
      chk("one_sel", selector, 1);
      chk("one_cnt", contador, k - 1);
      chk("one_valid", valid_out, k >= 2);
      if (k >= 2) chk("one_data", data_out, 2'b10);
    end
    req1 = 1'b0;
    tick();
    chk("idle_g1", grant1, 0);
    chk("idle_sel", selector, 1);
    chk("idle_valid", valid_out, 0);
    chk("idle_data", data_out, 2'b10);
    chk("idle_cnt", contador, 9);

    // early release of requester 0 after two transfers
    req0 = 1'b1; req1 = 1'b1; data_in0 = 2'b01; data_in1 = 2'b10;
    tick();
    chk("er_g0", grant0, 1);
    tick();
    chk("er_d1", data_out, 2'b01);
    chk("er_c1", contador, 10);
    tick();
    chk("er_c2", contador, 11);
    req0 = 1'b0;
    tick();
    chk("er_sw_g1", grant1, 1);
    chk("er_sw_valid", valid_out, 0);
    chk("er_sw_data", data_out, 2'b01);
    chk("er_sw_cnt", contador, 11);
    req0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("er_b_valid", valid_out, 1);
      chk("er_b_data", data_out, 2'b10);
      chk("er_b_cnt", contador, 11 + k);
      chk("er_b_g0", grant0, k == 4);
      chk("er_b_g1", grant1, k != 4);
    end
    tick();
    chk("er_back_data", data_out, 2'b01);
    chk("er_back_cnt", contador, 16);

    // counter wrap with requester 0 alone
    req0 = 1'b0; req1 = 1'b0;
    reset_pulse();
    req0 = 1'b1; data_in0 = 2'b11;
    for (int k = 1; k <= 65; k++) begin
      tick();
      chk("wrap_cnt", contador, (k - 1) % 64);
      chk("wrap_valid", valid_out, k >= 2);
      if (k >= 2) chk("wrap_data", data_out, 2'b11);
    end

    // random traffic with scoreboard and fairness tracking
    req0 = 1'b0; req1 = 1'b0;
    reset_pulse();
    sb = 0; w0 = 0; w1 = 0; max0 = 0; max1 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!req0 || grant0) data_in0 = 2'($urandom_range(0, 3));
      if (!req1 || grant1) data_in1 = 2'($urandom_range(0, 3));
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      xfer = (grant0 && req0) || (grant1 && req1);
      xd = grant1 ? data_in1 : data_in0;
      if (req0 && grant1 && req1) w0++;
      else if (!req0 || grant0) w0 = 0;
      if (req1 && grant0 && req0) w1++;
      else if (!req1 || grant1) w1 = 0;
      if (w0 > max0) max0 = w0;
      if (w1 > max1) max1 = w1;
      tick();
      if (xfer) sb++;
      chk("rnd_valid", valid_out, xfer);
      if (xfer) chk("rnd_data", data_out, xd);
      chk("rnd_cnt", contador, sb % 64);
    end
    chk("rnd_hold0", max0 <= 4, 1);
    chk("rnd_hold1", max1 <= 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
